// File: rtl/seg7_multi_display.sv
// Multi-digit 7-segment controller: double-dabble decimal or direct hex nibbles, dp/overflow, optional SEG7_LEADING_ZERO_BLANK_EN.
// Latency load->hex_out: hex 1 edge, decimal DATA_W+1 edges; load ignored (not queued) while busy.
module seg7_multi_display #(
  parameter int DATA_W     = 20,
  parameter int NUM_DIGITS = 6,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [DATA_W-1:0]       value,
  input  logic                    hex_mode,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic                    busy,
  output logic                    overflow,
  output logic [8*NUM_DIGITS-1:0] hex_out
);

  // BCD register must hold every digit of 2^DATA_W-1 and every displayed nibble in hex mode
  localparam int BCD_DIG = (DATA_W * 3) / 10 + 1;
  localparam int NDIG    = (BCD_DIG > NUM_DIGITS) ? BCD_DIG : NUM_DIGITS;
  localparam int BW      = 4 * NDIG;
  localparam int CW      = $clog2(DATA_W + 1);
  localparam logic [7:0] POL = (ACTIVE_LOW != 0) ? 8'h00 : 8'hFF;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] DEC_LIMIT = pow10(NUM_DIGITS);

  function automatic logic [7:0] seg_code(input logic [3:0] n);
    case (n)
      4'h0: seg_code = 8'hC0;  4'h1: seg_code = 8'hF9;
      4'h2: seg_code = 8'hA4;  4'h3: seg_code = 8'hB0;
      4'h4: seg_code = 8'h99;  4'h5: seg_code = 8'h92;
      4'h6: seg_code = 8'h82;  4'h7: seg_code = 8'hF8;
      4'h8: seg_code = 8'h80;  4'h9: seg_code = 8'h98;
      4'hA: seg_code = 8'h88;  4'hB: seg_code = 8'h83;
      4'hC: seg_code = 8'hC6;  4'hD: seg_code = 8'hA1;
      4'hE: seg_code = 8'h86;  default: seg_code = 8'h8E;
    endcase
  endfunction

  function automatic logic [3:0] adj3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t                  r_state, w_next;
  logic [CW-1:0]           r_cnt;
  logic [DATA_W-1:0]       r_shift;
  logic [BW-1:0]           r_bcd, w_bcd_sh;
  logic [3:0]              w_adj, w_nib;
  logic [7:0]              w_code;
  logic                    r_ovf, r_busy, r_overflow;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [8*NUM_DIGITS-1:0] r_hex, w_disp;
  logic [63:0]             w_val64;
  logic                    w_ovf_in;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic                    w_lead;
`endif

  assign w_val64  = {{(64-DATA_W){1'b0}}, value};
  assign w_ovf_in = hex_mode ? ((w_val64 >> (4*NUM_DIGITS)) != 64'd0) : (w_val64 >= DEC_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (load) w_next = hex_mode ? UPDATE : CONVERT;
      CONVERT: if (r_cnt == CW'(1)) w_next = UPDATE;
      UPDATE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // One double-dabble step: adjust nibbles >=5, then shift in the next value bit
  always_comb begin
    w_bcd_sh    = '0;
    w_adj       = '0;
    w_bcd_sh[0] = r_shift[DATA_W-1];
    for (int i = 0; i < NDIG-1; i++) begin
      w_adj = adj3(r_bcd[4*i +: 4]);
      w_bcd_sh[4*i+1 +: 4] = w_adj;
    end
    w_adj = adj3(r_bcd[BW-1 -: 4]);
    w_bcd_sh[BW-1 -: 3] = w_adj[2:0];
  end

  always_comb begin
    w_disp = '0;
    w_nib  = '0;
    w_code = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    w_lead = 1'b1;
`endif
    for (int i = NUM_DIGITS-1; i >= 0; i--) begin
      w_nib  = r_bcd[4*i +: 4];
      w_code = seg_code(w_nib);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      w_lead = w_lead && (w_nib == 4'd0) && (i != 0);
      if (w_lead) w_code = 8'hFF;
`endif
      if (r_ovf)   w_code = 8'hBF;
      if (r_dp[i]) w_code[7] = 1'b0;
      w_disp[8*i +: 8] = w_code ^ POL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_hex      <= {NUM_DIGITS{8'hFF ^ POL}};
      r_cnt      <= '0;
      r_shift    <= '0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
      r_dp       <= '0;
    end else begin
      case (r_state)
        IDLE: if (load) begin
          r_busy  <= 1'b1;
          r_ovf   <= w_ovf_in;
          r_dp    <= dp_mask;
          r_cnt   <= CW'(DATA_W);
          r_shift <= value;
          r_bcd   <= hex_mode ? {{(BW-DATA_W){1'b0}}, value} : '0;
        end
        CONVERT: begin
          r_bcd   <= w_bcd_sh;
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt - CW'(1);
        end
        UPDATE: begin
          r_hex      <= w_disp;
          r_overflow <= r_ovf;
          r_busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy     = r_busy;
  assign overflow = r_overflow;
  assign hex_out  = r_hex;

endmodule

// File: tb/tb_seg7_multi_display.sv
// Bench for seg7_multi_display: constant vector table, hand sequences, random loads vs an arithmetic model.
// Drives both polarities side by side; honours SEG7_LEADING_ZERO_BLANK_EN in its expectations.
module tb_seg7_multi_display;
  localparam int DW = 20;
  localparam int ND = 6;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, load, hex_mode;
  logic [DW-1:0] value;
  logic [ND-1:0] dp_mask;
  logic          busy, overflow, busy_h, overflow_h;
  logic [8*ND-1:0] hex_out, hex_out_h;
  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  seg7_multi_display #(.DATA_W(DW), .NUM_DIGITS(ND), .ACTIVE_LOW(1)) u_dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .hex_mode(hex_mode),
    .dp_mask(dp_mask), .busy(busy), .overflow(overflow), .hex_out(hex_out));

  seg7_multi_display #(.DATA_W(DW), .NUM_DIGITS(ND), .ACTIVE_LOW(0)) u_dut_h (
    .clk(clk), .reset(reset), .load(load), .value(value), .hex_mode(hex_mode),
    .dp_mask(dp_mask), .busy(busy_h), .overflow(overflow_h), .hex_out(hex_out_h));

  typedef struct packed { logic ovf; logic [47:0] hex; } exp_t;
  typedef struct { logic [19:0] v; logic hm; logic [5:0] dp; logic [47:0] eh; logic eo; } vec_t;

  logic [7:0] seg_tab [16];
  vec_t tbl [10];

  function automatic exp_t model(input logic [19:0] v, input logic hm, input logic [5:0] dp);
    longint vv = longint'(v);
    longint p;
    int d [ND];
    int msd = 0;
    logic [7:0] c;
    exp_t e;
    p = 1;
    for (int k = 0; k < ND; k++) p = p * 10;
    e.ovf = hm ? (vv >= (longint'(1) << (4*ND))) : (vv >= p);
    e.hex = '0;
    for (int i = 0; i < ND; i++) begin
      p = 1;
      for (int k = 0; k < i; k++) p = p * 10;
      d[i] = hm ? int'((vv >> (4*i)) & 15) : int'((vv / p) % 10);
      if (d[i] != 0) msd = i;
    end
    for (int i = 0; i < ND; i++) begin
      c = e.ovf ? 8'hBF : seg_tab[d[i]];
      if (LZB && !e.ovf && i > msd) c = 8'hFF;
      if (dp[i]) c[7] = 1'b0;
      e.hex[8*i +: 8] = c;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (busy && c < 100) begin @(posedge clk); #1; c++; end
    if (busy) chk({tag, ".idle_timeout"}, 64'(busy), 64'd0);
  endtask

  task automatic start_load(input logic [19:0] v, input logic hm, input logic [5:0] dp);
    value = v; hex_mode = hm; dp_mask = dp; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [47:0] eh, input logic eo);
    logic [47:0] inv;
    inv = ~eh;
    chk({tag, ".hex"}, 64'(hex_out), 64'(eh));
    chk({tag, ".ovf"}, 64'(overflow), 64'(eo));
    chk({tag, ".hex_al0"}, 64'(hex_out_h), 64'(inv));
    chk({tag, ".ovf_al0"}, 64'(overflow_h), 64'(eo));
  endtask

  task automatic run_load(input logic [19:0] v, input logic hm, input logic [5:0] dp,
                          input logic [47:0] eh, input logic eo, input string tag);
    int cyc = 0;
    wait_idle(tag);
    start_load(v, hm, dp);
    chk({tag, ".busy_set"}, 64'(busy), 64'd1);
    while (busy && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk({tag, ".latency"}, 64'(cyc), hm ? 64'd1 : 64'(DW + 1));
    check_out(tag, eh, eo);
  endtask

  initial begin
    exp_t e;
    int cyc;
    logic [19:0] rv;
    logic rh;
    logic [5:0] rd;

    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    tbl[0] = '{20'd123456,  1'b0, 6'b000000, 48'hF9A4B0999282, 1'b0};
    tbl[1] = '{20'hABCDE,   1'b1, 6'b000001, LZB ? 48'hFF8883C6A106 : 48'hC08883C6A106, 1'b0};
    tbl[2] = '{20'd1000000, 1'b0, 6'b000000, 48'hBFBFBFBFBFBF, 1'b1};
    tbl[3] = '{20'd42,      1'b0, 6'b000000, LZB ? 48'hFFFFFFFF99A4 : 48'hC0C0C0C099A4, 1'b0};
    tbl[4] = '{20'd0,       1'b0, 6'b000000, LZB ? 48'hFFFFFFFFFFC0 : 48'hC0C0C0C0C0C0, 1'b0};
    tbl[5] = '{20'd999999,  1'b0, 6'b100000, 48'h189898989898, 1'b0};
    tbl[6] = '{20'hFFFFF,   1'b1, 6'b111111, LZB ? 48'h7F0E0E0E0E0E : 48'h400E0E0E0E0E, 1'b0};
    tbl[7] = '{20'hFFFFF,   1'b0, 6'b010101, 48'hBF3FBF3FBF3F, 1'b1};
    tbl[8] = '{20'd100000,  1'b0, 6'b000000, 48'hF9C0C0C0C0C0, 1'b0};
    tbl[9] = '{20'd1,       1'b0, 6'b000000, LZB ? 48'hFFFFFFFFFFF9 : 48'hC0C0C0C0C0F9, 1'b0};

    reset = 1'b1; load = 1'b0; value = '0; hex_mode = 1'b0; dp_mask = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.hex", 64'(hex_out), 64'hFFFFFFFFFFFF);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.ovf", 64'(overflow), 64'd0);
    chk("reset.hex_al0", 64'(hex_out_h), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      run_load(tbl[i].v, tbl[i].hm, tbl[i].dp, tbl[i].eh, tbl[i].eo, $sformatf("vec%0d", i));

    // Load while busy is dropped; display holds until the first load completes
    run_load(20'd123456, 1'b0, 6'd0, 48'hF9A4B0999282, 1'b0, "pre");
    start_load(20'd42, 1'b0, 6'd0);
    cyc = 0;
    repeat (4) begin @(posedge clk); #1; cyc++; end
    start_load(20'd7, 1'b0, 6'd0);
    cyc++;
    chk("ign.hold", 64'(hex_out), 64'hF9A4B0999282);
    chk("ign.busy", 64'(busy), 64'd1);
    while (busy && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("ign.latency", 64'(cyc), 64'(DW + 1));
    check_out("ign", LZB ? 48'hFFFFFFFF99A4 : 48'hC0C0C0C099A4, 1'b0);

    // Reset in the middle of a conversion blanks the display with no late update
    run_load(20'd1000000, 1'b0, 6'd0, 48'hBFBFBFBFBFBF, 1'b1, "ovf");
    start_load(20'd999, 1'b0, 6'd0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst.hex", 64'(hex_out), 64'hFFFFFFFFFFFF);
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.ovf", 64'(overflow), 64'd0);
    chk("midrst.hex_al0", 64'(hex_out_h), 64'd0);
    repeat (30) @(posedge clk);
    #1;
    chk("midrst.hex_late", 64'(hex_out), 64'hFFFFFFFFFFFF);
    chk("midrst.busy_late", 64'(busy), 64'd0);

    for (int k = 0; k < 40; k++) begin
      rv = (k % 3 == 0) ? 20'($urandom_range(0, 999)) : 20'($urandom_range(0, 20'hFFFFF));
      rh = 1'($urandom_range(0, 1));
      rd = 6'($urandom);
      e  = model(rv, rh, rd);
      run_load(rv, rh, rd, e.hex, e.ovf, $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
